// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// ALUFun encodings and an operand-magnitude helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_e;

  localparam logic [5:0] ALUFUN_ADD = 6'b000000;
  localparam logic [5:0] ALUFUN_SUB = 6'b000001;

  // Magnitude of v when treated as signed; 0x80000000 maps to itself (unsigned 2^31).
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline and ALU connection bundle for mdu_sequencer; dbg_state exposes the FSM.
interface mdu_if;
  import mdu_pkg::*;

  // Handshake: start is sampled only while idle; busy is high from the cycle
  // after acceptance through FIX; done pulses for one cycle with HI/LO already
  // updated. cancel aborts any non-idle state; hi_we/lo_we act only when idle
  // and lose to an accepted start in the same cycle.
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] alu_s;
  mdu_state_e  dbg_state;

  modport slave (
    input  start, op, rs, rt, cancel, hi_we, lo_we, wdata, alu_s,
    output busy, done, hi, lo, alu_a, alu_b, alu_fun, alu_sign, dbg_state
  );

  modport master (
    output start, op, rs, rt, cancel, hi_we, lo_we, wdata, alu_s,
    input  busy, done, hi, lo, alu_a, alu_b, alu_fun, alu_sign, dbg_state
  );

endinterface

// File: rtl/mdu_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer (fixed 35-cycle latency) driving an external ALU; owns HI/LO.
// Build option MDU_DIV_EN enables the restoring-divide path; without it DIV/DIVU return zero.
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  mdu_state_e  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rs_q, rs_d, rt_q, rt_d;
  logic [31:0] acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_fun;
  logic        is_signed, is_div, carry;
  logic [31:0] mag_rs, mag_rt;
  logic [63:0] prod;
`ifdef MDU_DIV_EN
  logic        rsgn_q, rsgn_d;
  logic [31:0] t;
  logic        take;
`endif

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];
  assign mag_rs    = abs32(rs_q, is_signed);
  assign mag_rt    = abs32(rt_q, is_signed);
  assign carry     = bus.alu_s < acc_q;
  assign prod      = {acc_q, mq_q};
`ifdef MDU_DIV_EN
  // Partial remainder shifted left with the next dividend bit; acc_q[31] means t overflowed 32 bits.
  assign t    = {acc_q[30:0], mq_q[31]};
  assign take = acc_q[31] | (t >= opnd_q);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    alu_fun = ALUFUN_ADD;
`ifdef MDU_DIV_EN
    rsgn_d  = rsgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          state_d = PREP;
          op_d    = bus.op;
          rs_d    = bus.rs;
          rt_d    = bus.rt;
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      PREP: begin
        state_d = ITER;
        cnt_d   = 5'd0;
        acc_d   = 32'd0;
        mq_d    = is_div ? mag_rs : mag_rt;
        opnd_d  = is_div ? mag_rt : mag_rs;
        sgn_d   = is_signed & (rs_q[31] ^ rt_q[31]);
`ifdef MDU_DIV_EN
        rsgn_d  = is_signed & rs_q[31];
`endif
      end
      ITER: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
        if (!is_div) begin
          alu_a = acc_q;
          alu_b = mq_q[0] ? opnd_q : 32'd0;
          acc_d = {carry, bus.alu_s[31:1]};
          mq_d  = {bus.alu_s[0], mq_q[31:1]};
        end
`ifdef MDU_DIV_EN
        else begin
          alu_fun = ALUFUN_SUB;
          alu_a   = t;
          alu_b   = opnd_q;
          acc_d   = take ? bus.alu_s : t;
          mq_d    = {mq_q[30:0], take};
        end
`endif
      end
      FIX: begin
        state_d = DONE;
        if (!is_div) begin
          {hi_d, lo_d} = sgn_q ? (~prod + 64'd1) : prod;
        end else begin
`ifdef MDU_DIV_EN
          if (opnd_q == 32'd0) begin
            hi_d = rs_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rsgn_q ? (~acc_q + 32'd1) : acc_q;
            lo_d = sgn_q ? (~mq_q + 32'd1) : mq_q;
          end
`else
          hi_d = 32'd0;
          lo_d = 32'd0;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush abandons the operation before anything reaches HI/LO.
    if (state_q != IDLE && bus.cancel) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      acc_q   <= 32'd0;
      mq_q    <= 32'd0;
      opnd_q  <= 32'd0;
      cnt_q   <= 5'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_DIV_EN
      rsgn_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      rsgn_q  <= rsgn_d;
`endif
    end
  end

  assign bus.busy      = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_fun   = alu_fun;
  assign bus.alu_sign  = 1'b0;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer; acts as the ALU and checks results, latency, cancel and reset.
module tb_mdu_sequencer;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [63:0] exp_q[$];

  mdu_if bus();

  mdu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational ALU seen by the sequencer
  assign bus.alu_s = (bus.alu_fun == ALUFUN_SUB) ? (bus.alu_a - bus.alu_b)
                                                 : (bus.alu_a + bus.alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dv(input logic [31:0] x);
    return DIV_EN ? x : 32'd0;
  endfunction

  // Drives one start pulse; returns #1 into cycle 1 (the PREP cycle).
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts cycles from cycle 1 until done (bounded), tallying cycles where busy was low.
  task automatic wait_done(output int cyc, output int busy_bad, output logic [5:0] fun2);
    bit seen;
    seen = 1'b0; cyc = 1; busy_bad = 0; fun2 = 6'h3F;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (cyc == 2) fun2 = bus.alu_fun;
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        if (bus.busy !== 1'b1) busy_bad++;
        cyc++;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    int cyc, bb;
    logic [5:0]  fun2, exp_fun;
    logic [63:0] exp;
    exp_q.push_back({exp_hi, exp_lo});
    exp_fun = (op[1] && DIV_EN) ? ALUFUN_SUB : ALUFUN_ADD;
    start_op(op, a, b);
    wait_done(cyc, bb, fun2);
    exp = exp_q.pop_front();
    total_cnt++; if (cyc !== 35) $display("FAIL %s latency: got %0d want 35", name, cyc); else pass_cnt++;
    total_cnt++; if (bb !== 0) $display("FAIL %s busy_low: got %0d cycles want 0", name, bb); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy); else pass_cnt++;
    total_cnt++; if (fun2 !== exp_fun) $display("FAIL %s alu_fun: got %b want %b", name, fun2, exp_fun); else pass_cnt++;
    total_cnt++; if (bus.hi !== exp[63:32]) $display("FAIL %s hi: got %h want %h", name, bus.hi, exp[63:32]); else pass_cnt++;
    total_cnt++; if (bus.lo !== exp[31:0]) $display("FAIL %s lo: got %h want %h", name, bus.lo, exp[31:0]); else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if ({bus.hi, bus.lo} !== 64'd0) $display("FAIL reset hilo: got %h want 0", {bus.hi, bus.lo}); else pass_cnt++;
    total_cnt++; if ({bus.alu_a, bus.alu_b} !== 64'd0) $display("FAIL reset alu_ab: got %h want 0", {bus.alu_a, bus.alu_b}); else pass_cnt++;
    total_cnt++; if ({bus.alu_fun, bus.alu_sign} !== 7'd0) $display("FAIL reset alu_fun_sign: got %b want 0", {bus.alu_fun, bus.alu_sign}); else pass_cnt++;
    total_cnt++; if (bus.dbg_state !== IDLE) $display("FAIL reset state: got %0d want %0d", bus.dbg_state, IDLE); else pass_cnt++;
    #1 reset = 1'b0;
  endtask

  task automatic test_cancel();
    int done_seen;
    done_seen = 0;
    @(posedge clk); #1;
    bus.hi_we = 1'b1; bus.wdata = 32'h11;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    total_cnt++; if (bus.hi !== 32'h11) $display("FAIL mthi: got %h want 00000011", bus.hi); else pass_cnt++;
    // start accepted together with an MTHI: the write must be dropped
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.rs = 32'd5; bus.rt = 32'd6;
    bus.hi_we = 1'b1; bus.wdata = 32'h99;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus.cancel = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL cancel busy_c10: got %b want 1", bus.busy); else pass_cnt++;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL cancel busy_c11: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.dbg_state !== IDLE) $display("FAIL cancel state: got %0d want %0d", bus.dbg_state, IDLE); else pass_cnt++;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    total_cnt++; if (done_seen !== 0) $display("FAIL cancel done: got %0d pulses want 0", done_seen); else pass_cnt++;
    total_cnt++; if (bus.hi !== 32'h11) $display("FAIL cancel hi: got %h want 00000011", bus.hi); else pass_cnt++;
    total_cnt++; if (bus.lo !== 32'h0) $display("FAIL cancel lo: got %h want 00000000", bus.lo); else pass_cnt++;
  endtask

  task automatic test_multiply();
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq");
    run_op(MDU_MULTU, 32'h8000_0000, 32'd4,         32'h0000_0002, 32'h0000_0000, "multu_shift");
    run_op(MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1m1");
  endtask

  task automatic test_divide();
    run_op(MDU_DIV,  32'hFFFF_FFF9, 32'd2,         dv(32'hFFFF_FFFF), dv(32'hFFFF_FFFD), "div_neg7_2");
    run_op(MDU_DIVU, 32'd100,       32'd7,         dv(32'd2),         dv(32'd14),        "divu_100_7");
    run_op(MDU_DIV,  32'd7,         32'hFFFF_FFFE, dv(32'd1),         dv(32'hFFFF_FFFD), "div_7_neg2");
    run_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, dv(32'd0),         dv(32'h8000_0000), "div_ovf");
  endtask

  task automatic test_div_by_zero();
    run_op(MDU_DIVU, 32'h64,        32'd0, dv(32'h64),        dv(32'hFFFF_FFFF), "divu_by0");
    run_op(MDU_DIV,  32'hFFFF_FFFB, 32'd0, dv(32'hFFFF_FFFB), dv(32'hFFFF_FFFF), "div_by0");
  endtask

  task automatic test_back_to_back();
    int cyc, bb;
    logic [5:0] fun2;
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "b2b_first");
    // Now in the DONE cycle: a start raised here must not be taken until the next cycle
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.rs = 32'd3; bus.rt = 32'd5;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL b2b busy_c36: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.dbg_state !== IDLE) $display("FAIL b2b state_c36: got %0d want %0d", bus.dbg_state, IDLE); else pass_cnt++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(cyc, bb, fun2);
    total_cnt++; if (cyc !== 35) $display("FAIL b2b latency: got %0d want 35", cyc); else pass_cnt++;
    total_cnt++; if ({bus.hi, bus.lo} !== 64'd15) $display("FAIL b2b hilo: got %h want 15", {bus.hi, bus.lo}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    start_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    repeat (19) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total_cnt++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL rst_mid busy_done: got %b want 00", {bus.busy, bus.done}); else pass_cnt++;
    total_cnt++; if ({bus.hi, bus.lo} !== 64'd0) $display("FAIL rst_mid hilo: got %h want 0", {bus.hi, bus.lo}); else pass_cnt++;
    total_cnt++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== 70'd0) $display("FAIL rst_mid alu: got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_fun}); else pass_cnt++;
    total_cnt++; if (bus.dbg_state !== IDLE) $display("FAIL rst_mid state: got %0d want %0d", bus.dbg_state, IDLE); else pass_cnt++;
    #2 reset = 1'b0;
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "after_reset");
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.rs = 32'd0; bus.rt = 32'd0;
    bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'd0;
    test_reset();
    test_cancel();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide unit for the MIPS32 pipeline. It implements MULT, MULTU, DIV and DIVU by driving a dedicated ALU instance through 32 add/subtract iterations and owns the HI/LO registers. It sits beside the EX stage: the pipeline starts an operation, stalls on `busy`, and reads `hi`/`lo` after `done`. It also accepts MTHI/MTLO writes and a pipeline flush.

## Interface
- No parameters. Datapath is fixed at 32 bits.

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin operation; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `rs`  in  32  multiplicand / dividend
- `rt`  in  32  multiplier / divisor
- `cancel`  in  1  flush; aborts an in-flight operation
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write strobes
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  high from the cycle after start acceptance through FIX
- `done`  out  1  one-cycle pulse when the result is committed
- `hi`, `lo`  out  32 each  HI/LO registers
- `alu_a`, `alu_b`  out  32 each  ALU operands
- `alu_fun`  out  6  ALUFun: 000000 ADD, 000001 SUB
- `alu_sign`  out  1  held at 0 (unsigned)
- `alu_s`  in  32  ALU result, combinational return

## Operation
- States and transitions:
  - IDLE -> PREP on `start`.
  - PREP -> ITER. PREP latches `|rs|` and `|rt|`; magnitudes are taken only for signed ops, using local negation. It also records the result signs: quotient/product = sign(rs) ^ sign(rt), remainder = sign(rs).
  - ITER runs 32 cycles, counted by a 5-bit counter; last count -> FIX.
  - FIX applies two's-complement correction to the 64-bit result -> DONE.
  - DONE commits HI/LO and pulses `done` -> IDLE.
- Multiply (shift-add):
  - Initial state: acc = 0, mq = |rt|.
  - Each ITER cycle: `alu_fun` = ADD, `alu_a` = acc, `alu_b` = mq[0] ? mcand : 0.
  - carry = (`alu_s` < acc), unsigned, computed locally.
  - {acc, mq} <= {carry, `alu_s`, mq[31:1]}.
  - Final: HI = acc, LO = mq.
- Divide (restoring):
  - Initial state: r = 0, q = |rs|.
  - Each ITER cycle: t = {r[30:0], q[31]}, ovf = r[31]; `alu_fun` = SUB, `alu_a` = t, `alu_b` = divisor.
  - If ovf or t >= divisor: r <= `alu_s` and the quotient bit is 1. Otherwise r <= t and the quotient bit is 0.
  - q shifts left, taking the quotient bit in at bit 0.
  - Final: HI = r, LO = q.
- Divide by zero: no exception; HI = rs (unmodified), LO = 0xFFFFFFFF, normal latency.
- Signed overflow: 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- `start` while busy: ignored.
- `cancel`: any non-IDLE state -> IDLE on the next edge; no `done` pulse; HI/LO unchanged. `cancel` with `start` in IDLE: start is dropped.
- `hi_we` / `lo_we`: honoured only in IDLE, ignored while busy. If `start` is accepted in the same cycle, `start` wins and the write is dropped.
- Outside ITER: `alu_a` = `alu_b` = 0, `alu_fun` = ADD.

## Timing
- Reset values:
  - state IDLE
  - `busy` = 0, `done` = 0
  - `hi` = `lo` = 0
  - `alu_a` = `alu_b` = 0, `alu_fun` = 000000, `alu_sign` = 0
- Cycle numbering: `start` sampled at edge 0.
  - PREP: cycle 1; `busy` = 1 from cycle 1.
  - ITER: cycles 2–33.
  - FIX: cycle 34.
  - DONE: cycle 35; `done` = 1, new `hi`/`lo` visible in the same cycle, `busy` = 0.
- Start-to-done latency is fixed at 35 cycles for all ops and operands.
- A new `start` is accepted in cycle 36 at the earliest; a `start` asserted during the DONE cycle is ignored.
- `alu_s` is consumed in the same cycle the operands are driven; the ALU is purely combinational.
- Reset mid-operation returns to IDLE immediately (asynchronous) and clears HI/LO.

## Configuration
- `MDU_DIV_EN` defined: full divide path as above.
- Undefined: the divide compare/restore logic is removed. DIV/DIVU are still accepted with identical 35-cycle timing, `alu_fun` stays ADD with zero operands, and the result is HI = LO = 0.

## Structure
- Package `mdu_pkg` holds:
  - op codes (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`)
  - state enum (IDLE, PREP, ITER, FIX, DONE)
  - ALUFun constants `ALUFUN_ADD` = 6'b000000, `ALUFUN_SUB` = 6'b000001
- No internal sub-module. The ALU is instanced by the parent and connected through the `alu_*` ports.

## Test plan
- MULTU rs = rt = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; `done` exactly 35 cycles after `start`; `busy` high cycles 1–34.
- MULT rs = 0xFFFFFFFD (-3), rt = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV rs = 0xFFFFFFF9 (-7), rt = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU rs = 100, rt = 7 -> lo = 14, hi = 2.
- DIVU rs = 0x64, rt = 0 -> hi = 0x64, lo = 0xFFFFFFFF at cycle 35.
- Preload hi = 0x11 via `hi_we`, start MULTU, assert `cancel` in cycle 10 -> `busy` = 0 from cycle 11, no `done`, hi stays 0x11. A `start` pulsed in cycle 5 is ignored.
- Assert `reset` in cycle 20 of a MULT -> all outputs return to reset values immediately; the next `start` completes normally with 35-cycle latency.
